// File: rtl/rmw_pkg.sv
// Shared definitions for the register-bank read-modify-write sweeper.
//   state_t         : sequencer states (IDLE, READ, WAIT, WRITE)
//   RMW_*           : default parameter values used by reg_sweep_rmw
package rmw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int RMW_DATA_WIDTH   = 32;
  localparam int RMW_ADDR_WIDTH   = 5;
  localparam int RMW_FIRST_REG    = 1;
  localparam int RMW_LAST_REG     = 31;
  localparam int RMW_READ_LATENCY = 1;
  localparam int RMW_PASS_WIDTH   = 16;

endpackage

// File: rtl/rmw_wait_timer.sv
// Loadable down-counter that sets the length of the WAIT state.
// Loaded with LATENCY-1 while the sequencer is in READ, it then counts
// down once per cycle; o_last is high in the final WAIT cycle (count == 0).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_load  : reload the counter (asserted during READ)
//   o_last  : current WAIT cycle is the last one
module rmw_wait_timer #(
  parameter int LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_last
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == '0);

endmodule

// File: rtl/reg_sweep_rmw.sv
// Register-bank read-modify-write sequencer. Sweeps registers
// FIRST_REG..LAST_REG: reads each one through the bank's second read port,
// adds a latched step, and writes the result back. One-shot or continuous.
//
// Build option: define RMW_SATURATE_EN to make the add saturate at
// 2^DATA_WIDTH-1 instead of wrapping.
//
// Ports:
//   i_clock        : clock, rising edge
//   i_reset        : asynchronous active-high reset
//   i_start        : begin a sweep (sampled only in IDLE)
//   i_continuous   : latched at start; repeat sweeps until stopped
//   i_stop         : end after the current register's write (sticky)
//   i_step         : increment, latched at start
//   o_rd_address   : read address to the bank
//   o_rd           : read strobe
//   i_rd_data      : read data, valid READ_LATENCY cycles after the read edge
//   o_wr_address   : write address to the bank
//   o_wr           : write strobe (never asserted for register 0)
//   o_wr_data      : write data
//   o_busy         : high in any state but IDLE
//   o_done         : one-cycle pulse when a full sweep completes
//   o_pass_count   : completed sweeps since reset, wrapping
module reg_sweep_rmw
  import rmw_pkg::*;
#(
  parameter int DATA_WIDTH   = RMW_DATA_WIDTH,
  parameter int ADDR_WIDTH   = RMW_ADDR_WIDTH,
  parameter int FIRST_REG    = RMW_FIRST_REG,
  parameter int LAST_REG     = RMW_LAST_REG,
  parameter int READ_LATENCY = RMW_READ_LATENCY,
  parameter int PASS_WIDTH   = RMW_PASS_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic                  i_stop,
  input  logic [DATA_WIDTH-1:0] i_step,
  output logic [ADDR_WIDTH-1:0] o_rd_address,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [ADDR_WIDTH-1:0] o_wr_address,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PASS_WIDTH-1:0] o_pass_count
);

  localparam logic [ADDR_WIDTH-1:0] LP_FIRST = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(LAST_REG);

`ifdef RMW_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Unsigned add; on carry-out either clamp to all-ones or keep the low bits.
  function automatic logic [DATA_WIDTH-1:0] rmw_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (SAT_EN && s[DATA_WIDTH]) ? '1 : s[DATA_WIDTH-1:0];
  endfunction

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [DATA_WIDTH-1:0] r_step;
  logic                  r_continuous;
  logic                  r_stop_seen;
  logic [ADDR_WIDTH-1:0] r_rd_address;
  logic                  r_rd;
  logic [ADDR_WIDTH-1:0] r_wr_address;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_busy;
  logic                  r_done;
  logic [PASS_WIDTH-1:0] r_pass_count;

  logic                  w_wait_last;
  logic                  w_timer_load;
  logic                  w_stop_req;
  logic                  w_at_last;
  logic [ADDR_WIDTH-1:0] w_next_cur;
  logic [DATA_WIDTH-1:0] w_sum;

  assign w_timer_load = (r_state == READ);
  // A stop arriving in the WRITE cycle itself still ends the run after that write.
  assign w_stop_req   = r_stop_seen | i_stop;
  assign w_at_last    = (r_cur == LP_LAST);
  assign w_next_cur   = w_at_last ? LP_FIRST : r_cur + 1'b1;
  assign w_sum        = rmw_add(i_rd_data, r_step);

  rmw_wait_timer #(
    .LATENCY (READ_LATENCY)
  ) u_wait_timer (
    .i_clk  (i_clock),
    .i_rst  (i_reset),
    .i_load (w_timer_load),
    .o_last (w_wait_last)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cur        <= '0;
      r_step       <= '0;
      r_continuous <= 1'b0;
      r_stop_seen  <= 1'b0;
      r_rd_address <= '0;
      r_rd         <= 1'b0;
      r_wr_address <= '0;
      r_wr         <= 1'b0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass_count <= '0;
    end else begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // A stop seen together with start is dropped.
          r_stop_seen <= 1'b0;
          if (i_start) begin
            r_step       <= i_step;
            r_continuous <= i_continuous;
            r_cur        <= LP_FIRST;
            r_rd         <= 1'b1;
            r_rd_address <= LP_FIRST;
            r_busy       <= 1'b1;
            r_state      <= READ;
          end
        end
        READ: begin
          r_stop_seen <= w_stop_req;
          r_state     <= WAIT;
        end
        WAIT: begin
          r_stop_seen <= w_stop_req;
          if (w_wait_last) begin
            r_wr_data    <= w_sum;
            r_wr_address <= r_cur;
            r_wr         <= (r_cur != '0);  // register 0 is hardwired
            r_state      <= WRITE;
          end
        end
        WRITE: begin
          if (w_at_last) begin
            r_done       <= 1'b1;
            r_pass_count <= r_pass_count + 1'b1;
          end
          if (w_stop_req || (w_at_last && !r_continuous)) begin
            r_busy      <= 1'b0;
            r_stop_seen <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cur        <= w_next_cur;
            r_rd         <= 1'b1;
            r_rd_address <= w_next_cur;
            r_state      <= READ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rd_address = r_rd_address;
  assign o_rd         = r_rd;
  assign o_wr_address = r_wr_address;
  assign o_wr         = r_wr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass_count = r_pass_count;

endmodule

// File: tb/tb_reg_sweep_rmw.sv
// Bench for reg_sweep_rmw. Three instances with different ranges and read
// latencies share one clock/reset; each has its own register-bank model.
// Expected writes are queued when a sweep is started and matched as the
// DUT's write strobes appear.
`timescale 1ns/1ps
module tb_reg_sweep_rmw;

  localparam int NI = 3;

  function automatic int fr(input int g);
    return (g == 2) ? 0 : 1;
  endfunction
  function automatic int lr(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 1 : 2);
  endfunction
  function automatic int rl(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start [NI];
  logic        cont  [NI];
  logic        stop  [NI];
  logic [31:0] step  [NI];
  logic [4:0]  ra    [NI];
  logic        rd    [NI];
  logic [31:0] rdata [NI];
  logic [4:0]  wa    [NI];
  logic        wr    [NI];
  logic [31:0] wd    [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic [15:0] pass  [NI];

  logic [31:0] mem  [NI][32];
  logic [31:0] pipe [NI][3];
  logic [31:0] mdl  [NI][32];
  logic        poke_en;
  int          poke_g;
  logic [4:0]  poke_a;
  logic [31:0] poke_d;

  wr_t exp_q [NI][$];
  wr_t mon_e;
  int  done_cnt [NI];
  int  done_cyc [NI];
  int  wr0_cnt  [NI];
  int  t0       [NI];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;

`ifdef RMW_SATURATE_EN
  localparam logic [31:0] EXP_OVF = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_OVF = 32'h0000_0000;
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_sweep_rmw #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (5),
      .FIRST_REG    (fr(g)),
      .LAST_REG     (lr(g)),
      .READ_LATENCY (rl(g)),
      .PASS_WIDTH   (16)
    ) u_dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_start      (start[g]),
      .i_continuous (cont[g]),
      .i_stop       (stop[g]),
      .i_step       (step[g]),
      .o_rd_address (ra[g]),
      .o_rd         (rd[g]),
      .i_rd_data    (rdata[g]),
      .o_wr_address (wa[g]),
      .o_wr         (wr[g]),
      .o_wr_data    (wd[g]),
      .o_busy       (busy[g]),
      .o_done       (done[g]),
      .o_pass_count (pass[g])
    );
    assign rdata[g] = pipe[g][rl(g)-1];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: writes land at the strobe edge; reads return after rl() edges.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (wr[g]) mem[g][wa[g]] <= wd[g];
      pipe[g][0] <= rd[g] ? mem[g][ra[g]] : 32'hDEAD_BEEF;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
    if (poke_en) mem[poke_g][poke_a] <= poke_d;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (wr[g] === 1'b1) begin
        if (wa[g] == 5'd0) wr0_cnt[g]++;
        check_eq($sformatf("wr%0d_expected", g), 64'(exp_q[g].size() != 0), 64'd1);
        if (exp_q[g].size() != 0) begin
          mon_e = exp_q[g].pop_front();
          check_eq($sformatf("wr%0d_addr", g), 64'(wa[g]), 64'(mon_e.a));
          check_eq($sformatf("wr%0d_data", g), 64'(wd[g]), 64'(mon_e.d));
        end
      end
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
      end
    end
  end

  function automatic logic [31:0] mdl_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef RMW_SATURATE_EN
    if (s[32]) return 32'hFFFF_FFFF;
`endif
    return s[31:0];
  endfunction

  task automatic poke(input int g, input int a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_g = g; poke_a = 5'(a); poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
    mdl[g][a] = d;
  endtask

  task automatic push_wr(input int g, input int a, input logic [31:0] st);
    wr_t e;
    mdl[g][a] = mdl_add(mdl[g][a], st);
    e.a = 5'(a);
    e.d = mdl[g][a];
    exp_q[g].push_back(e);
  endtask

  task automatic push_sweep(input int g, input logic [31:0] st);
    for (int a = fr(g); a <= lr(g); a++)
      if (a != 0) push_wr(g, a, st);
  endtask

  task automatic do_start(input int g, input logic [31:0] st, input logic c, input logic sp);
    @(negedge clk);
    step[g] = st; cont[g] = c; stop[g] = sp; start[g] = 1'b1;
    @(posedge clk);
    #1;
    t0[g] = cyc;
    start[g] = 1'b0;
    stop[g]  = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n;
    n = 0;
    while (busy[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("idle%0d_in_budget", g), 64'(busy[g]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    poke_en = 1'b0; poke_g = 0; poke_a = '0; poke_d = '0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; cont[g] = 1'b0; stop[g] = 1'b0; step[g] = '0;
      done_cnt[g] = 0; done_cyc[g] = 0; wr0_cnt[g] = 0; t0[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check_eq($sformatf("rst%0d_strobes", g), 64'({rd[g], wr[g], busy[g], done[g]}), 64'd0);
      check_eq($sformatf("rst%0d_pass", g), 64'(pass[g]), 64'd0);
      check_eq($sformatf("rst%0d_addr_data", g), {27'd0, ra[g], wa[g], wd[g]}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // One-shot sweep x1..x3 from zero, step 1.
    poke(0, 1, 0); poke(0, 2, 0); poke(0, 3, 0); poke(0, 4, 32'h1234);
    push_sweep(0, 32'd1);
    do_start(0, 32'd1, 1'b0, 1'b0);
    wait_idle(0, 60);
    check_eq("t1_done_cycle", 64'(done_cyc[0] - t0[0]), 64'd9);
    check_eq("t1_done_count", 64'(done_cnt[0]), 64'd1);
    check_eq("t1_pass", 64'(pass[0]), 64'd1);
    check_eq("t1_x1", 64'(mem[0][1]), 64'd1);
    check_eq("t1_x2", 64'(mem[0][2]), 64'd1);
    check_eq("t1_x3", 64'(mem[0][3]), 64'd1);
    check_eq("t1_x4_untouched", 64'(mem[0][4]), 64'h1234);
    check_eq("t1_queue_drained", 64'(exp_q[0].size()), 64'd0);

    // Stop raised in WAIT of x2 for one cycle only: x2 written, x3 untouched.
    poke(0, 1, 10); poke(0, 2, 20); poke(0, 3, 30);
    push_wr(0, 1, 32'd1);
    push_wr(0, 2, 32'd1);
    do_start(0, 32'd1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    wait_idle(0, 60);
    check_eq("t3_x1", 64'(mem[0][1]), 64'd11);
    check_eq("t3_x2", 64'(mem[0][2]), 64'd21);
    check_eq("t3_x3_untouched", 64'(mem[0][3]), 64'd30);
    check_eq("t3_no_done", 64'(done_cnt[0]), 64'd1);
    check_eq("t3_pass", 64'(pass[0]), 64'd1);
    check_eq("t3_queue_drained", 64'(exp_q[0].size()), 64'd0);

    // Start with stop in IDLE: start wins, full sweep with step 2.
    push_sweep(0, 32'd2);
    do_start(0, 32'd2, 1'b0, 1'b1);
    wait_idle(0, 60);
    check_eq("t3b_x3", 64'(mem[0][3]), 64'd32);
    check_eq("t3b_pass", 64'(pass[0]), 64'd2);
    check_eq("t3b_done_count", 64'(done_cnt[0]), 64'd2);
    check_eq("t3b_queue_drained", 64'(exp_q[0].size()), 64'd0);

    // Reset in WAIT of x1: everything drops at once, no write issued.
    poke(0, 1, 32'h77);
    do_start(0, 32'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t5_strobes_drop", 64'({rd[0], wr[0], busy[0]}), 64'd0);
    check_eq("t5_pass_cleared", 64'(pass[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t5_x1_unchanged", 64'(mem[0][1]), 64'h77);
    check_eq("t5_idle", 64'({busy[0], pass[0]}), 64'd0);

    // Continuous single register, step 5; stop requested inside the 4th sweep.
    poke(1, 1, 0);
    for (int k = 0; k < 4; k++) push_sweep(1, 32'd5);
    do_start(1, 32'd5, 1'b1, 1'b0);
    n = 0;
    while (done_cnt[1] < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t2_three_dones_in_budget", 64'(done_cnt[1] >= 3), 64'd1);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    wait_idle(1, 100);
    check_eq("t2_x1", 64'(mem[1][1]), 64'd20);
    check_eq("t2_pass", 64'(pass[1]), 64'd4);
    check_eq("t2_done_count", 64'(done_cnt[1]), 64'd4);
    check_eq("t2_busy", 64'(busy[1]), 64'd0);
    check_eq("t2_queue_drained", 64'(exp_q[1].size()), 64'd0);

    // Overflow: all-ones + 1 wraps or saturates depending on the build.
    poke(1, 1, 32'hFFFF_FFFF);
    push_sweep(1, 32'd1);
    do_start(1, 32'd1, 1'b0, 1'b0);
    wait_idle(1, 60);
    check_eq("t4_x1_overflow", 64'(mem[1][1]), 64'(EXP_OVF));
    check_eq("t4_pass", 64'(pass[1]), 64'd5);
    check_eq("t4_queue_drained", 64'(exp_q[1].size()), 64'd0);

    // Read latency 3, range x0..x2: 5 cycles per register, x0 never written,
    // a second start while busy is ignored.
    poke(2, 0, 32'h55); poke(2, 1, 10); poke(2, 2, 20);
    push_sweep(2, 32'd3);
    do_start(2, 32'd3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start[2] = 1'b1; step[2] = 32'd100; cont[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0; step[2] = 32'd3; cont[2] = 1'b0;
    wait_idle(2, 100);
    check_eq("t6_done_cycle", 64'(done_cyc[2] - t0[2]), 64'd15);
    check_eq("t6_done_count", 64'(done_cnt[2]), 64'd1);
    check_eq("t6_pass", 64'(pass[2]), 64'd1);
    check_eq("t6_x0_untouched", 64'(mem[2][0]), 64'h55);
    check_eq("t6_x0_no_wr", 64'(wr0_cnt[2]), 64'd0);
    check_eq("t6_x1", 64'(mem[2][1]), 64'd13);
    check_eq("t6_x2", 64'(mem[2][2]), 64'd23);
    check_eq("t6_queue_drained", 64'(exp_q[2].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
